// File: rtl/tlb_responder.sv
// rtl/tlb_responder.sv - 32-entry joint TLB answering CP0 TLBR/TLBWI/TLBWR/TLBP requests
// Request bus is registered on entry; TLBP scans one entry per cycle.
module tlb_responder #(
  parameter int          ENTRIES    = 32,
  parameter logic [31:0] PROBE_MISS = 32'h8000_0000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [164:0]   cp0_tlb_bus,
  output logic [162:0]   tlb_cp0_bus
);

  localparam int IW = $clog2(ENTRIES);

  typedef enum logic [2:0] {IDLE, EXEC, PROBE, DONE, RELEASE} state_t;
  typedef enum logic [1:0] {OP_WI, OP_WR, OP_R, OP_P} op_t;

  state_t state, state_next;

  logic [164:0] bus_q;
  logic         in_valid;
  logic [31:0]  in_index, in_hi, in_pm, in_lo0, in_lo1;
  logic         in_r, in_p, in_wi, in_wr;

  assign {in_valid, in_index, in_hi, in_pm, in_lo0, in_lo1, in_r, in_p, in_wi, in_wr} = bus_q;

  logic unused_bits;
  assign unused_bits = ^{in_hi[12:8], in_pm[31:25], in_pm[12:0], in_lo0[31:26], in_lo1[31:26]};

  // Entry storage
  logic [18:0] e_vpn2 [ENTRIES];
  logic [7:0]  e_asid [ENTRIES];
  logic        e_g    [ENTRIES];
  logic [11:0] e_mask [ENTRIES];
  logic [19:0] e_pfn0 [ENTRIES];
  logic [2:0]  e_c0   [ENTRIES];
  logic        e_d0   [ENTRIES];
  logic        e_v0   [ENTRIES];
  logic [19:0] e_pfn1 [ENTRIES];
  logic [2:0]  e_c1   [ENTRIES];
  logic        e_d1   [ENTRIES];
  logic        e_v1   [ENTRIES];

  // Latched request
  op_t          op, op_next;
  logic [31:0]  q_index;
  logic [18:0]  q_vpn2;
  logic [7:0]   q_asid;
  logic [11:0]  q_mask;
  logic [25:0]  q_lo0, q_lo1;
  logic [IW-1:0] ptr;

  // Result registers presented during DONE
  logic [31:0]  r_index, r_hi, r_lo0, r_lo1, r_pm;
  logic         r_index_wen, r_cp0_wen;

  logic          accept;
  logic          idx_ok;
  logic [IW-1:0] idx;
  logic          wr_en;
  logic [18:0]   pmask;
  logic          probe_hit, probe_last;

  assign accept = in_valid && (in_r || in_p || in_wi || in_wr);
  assign idx_ok = (q_index >> IW) == 32'd0;
  assign idx    = q_index[IW-1:0];
  assign wr_en  = (state == EXEC) && ((op == OP_WI) || (op == OP_WR)) && idx_ok;

  always_comb begin
    op_next = OP_P;
    if (in_wi)      op_next = OP_WI;
    else if (in_wr) op_next = OP_WR;
    else if (in_r)  op_next = OP_R;
  end

  // Masked VPN2 compare against the entry under the scan pointer
  always_comb begin
    pmask      = {7'b0, e_mask[ptr]};
    probe_hit  = ((e_vpn2[ptr] & ~pmask) == (q_vpn2 & ~pmask)) &&
                 (e_g[ptr] || (e_asid[ptr] == q_asid));
    probe_last = (ptr == IW'(ENTRIES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (op_next == OP_P) ? PROBE : EXEC;
      EXEC:    state_next = DONE;
      PROBE:   if (probe_hit || probe_last) state_next = DONE;
      DONE:    state_next = RELEASE;
      RELEASE: if (!in_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q       <= '0;
      op          <= OP_WI;
      q_index     <= '0;
      q_vpn2      <= '0;
      q_asid      <= '0;
      q_mask      <= '0;
      q_lo0       <= '0;
      q_lo1       <= '0;
      ptr         <= '0;
      r_index     <= '0;
      r_index_wen <= 1'b0;
      r_cp0_wen   <= 1'b0;
      r_hi        <= '0;
      r_lo0       <= '0;
      r_lo1       <= '0;
      r_pm        <= '0;
    end else begin
      bus_q <= cp0_tlb_bus;
      case (state)
        IDLE: if (accept) begin
          op          <= op_next;
          q_index     <= in_index;
          q_vpn2      <= in_hi[31:13];
          q_asid      <= in_hi[7:0];
          q_mask      <= in_pm[24:13];
          q_lo0       <= in_lo0[25:0];
          q_lo1       <= in_lo1[25:0];
          ptr         <= '0;
          r_index     <= '0;
          r_index_wen <= 1'b0;
          r_cp0_wen   <= 1'b0;
          r_hi        <= '0;
          r_lo0       <= '0;
          r_lo1       <= '0;
          r_pm        <= '0;
        end
        EXEC: if (op == OP_R) begin
          r_cp0_wen <= 1'b1;
          if (idx_ok) begin
            r_hi  <= {e_vpn2[idx], 5'b0, e_asid[idx]};
            r_pm  <= {7'b0, e_mask[idx], 13'b0};
            r_lo0 <= {6'b0, e_pfn0[idx], e_c0[idx], e_d0[idx], e_v0[idx], e_g[idx]};
            r_lo1 <= {6'b0, e_pfn1[idx], e_c1[idx], e_d1[idx], e_v1[idx], e_g[idx]};
          end
        end
        PROBE: begin
          ptr <= ptr + 1'b1;
          if (probe_hit) begin
            r_index     <= 32'(ptr);
            r_index_wen <= 1'b1;
          end else if (probe_last) begin
            r_index     <= PROBE_MISS;
            r_index_wen <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        e_vpn2[i] <= '0;
        e_asid[i] <= '0;
        e_g[i]    <= 1'b0;
        e_mask[i] <= '0;
        e_pfn0[i] <= '0;
        e_c0[i]   <= '0;
        e_d0[i]   <= 1'b0;
        e_v0[i]   <= 1'b0;
        e_pfn1[i] <= '0;
        e_c1[i]   <= '0;
        e_d1[i]   <= 1'b0;
        e_v1[i]   <= 1'b0;
      end
    end else if (wr_en) begin
      e_vpn2[idx] <= q_vpn2;
      e_asid[idx] <= q_asid;
      e_g[idx]    <= q_lo0[0] & q_lo1[0];
      e_mask[idx] <= q_mask;
      e_pfn0[idx] <= q_lo0[25:6];
      e_c0[idx]   <= q_lo0[5:3];
      e_d0[idx]   <= q_lo0[2];
      e_v0[idx]   <= q_lo0[1];
      e_pfn1[idx] <= q_lo1[25:6];
      e_c1[idx]   <= q_lo1[5:3];
      e_d1[idx]   <= q_lo1[2];
      e_v1[idx]   <= q_lo1[1];
    end
  end

  always_comb begin
    tlb_cp0_bus = '0;
    if (state == DONE)
      tlb_cp0_bus = {r_index, r_index_wen, 1'b1, r_cp0_wen, r_hi, r_lo0, r_lo1, r_pm};
  end

endmodule
